// File: rtl/act_unit_arbiter.sv
// rtl/act_unit_arbiter.sv - round-robin sharing of one fixed-latency activation unit between two requesters
module act_unit_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int PIPE_LAT   = 3,
   parameter int OUT_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] r0_data,
   input  logic                  r0_valid,
   output logic                  r0_ready,
   output logic [DATA_WIDTH-1:0] r0_out_data,
   output logic                  r0_out_valid,
   input  logic                  r0_out_ready,
   input  logic [DATA_WIDTH-1:0] r1_data,
   input  logic                  r1_valid,
   output logic                  r1_ready,
   output logic [DATA_WIDTH-1:0] r1_out_data,
   output logic                  r1_out_valid,
   input  logic                  r1_out_ready,
   output logic [DATA_WIDTH-1:0] act_in_data,
   output logic                  act_in_valid,
   input  logic [DATA_WIDTH-1:0] act_hsigmoid,
   input  logic [DATA_WIDTH-1:0] act_hswish,
   input  logic                  act_out_valid,
   output logic                  busy,
   output logic                  err
);

   localparam int CW = $clog2(OUT_DEPTH + PIPE_LAT) + 1;
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);

   // Per-requester bookkeeping; index 0 is the hard-sigmoid path, index 1 the hard-swish path.
   logic [CW-1:0]         occ       [2];
   logic [CW-1:0]         inflight  [2];
   logic [PW-1:0]         wr_ptr    [2];
   logic [PW-1:0]         rd_ptr    [2];
   logic [DATA_WIDTH-1:0] mem       [2][OUT_DEPTH];
   logic [DATA_WIDTH-1:0] push_data [2];

   logic [1:0] req;
   logic [1:0] eligible;
   logic [1:0] win;
   logic [1:0] rel_tag;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] full;
   logic [1:0] out_valid;
   logic [1:0] out_ready;
   logic       last_grant;

   // Tag pipe mirrors the unit's pipeline: {valid, id} per stage, tail aligned with act_out_valid.
   logic [PIPE_LAT-1:0] tag_v;
   logic [PIPE_LAT-1:0] tag_id;
   logic                tail_v;
   logic                tail_id;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign tail_v  = tag_v[PIPE_LAT-1];
   assign tail_id = tag_id[PIPE_LAT-1];

   // Credit check and round-robin pick; a tie goes to the requester not granted last.
   always_comb begin
      req = {r1_valid, r0_valid};
      eligible = 2'b00;
      for (int i = 0; i < 2; i++) begin
         eligible[i] = req[i] && !rst && ((occ[i] + inflight[i]) < DEPTH_C);
      end
      if (eligible == 2'b11) begin
         win = last_grant ? 2'b01 : 2'b10;
      end else begin
         win = eligible;
      end
   end

   assign r0_ready     = win[0];
   assign r1_ready     = win[1];
   assign act_in_valid = |win;
   assign act_in_data  = win[1] ? r1_data : (win[0] ? r0_data : '0);

   // Steer the tail result to its owner's FIFO; the tail tag always frees its slot, result or not.
   always_comb begin
      push_data[0] = act_hsigmoid;
      push_data[1] = act_hswish;
      out_ready    = {r1_out_ready, r0_out_ready};
      rel_tag      = 2'b00;
      push         = 2'b00;
      out_valid    = 2'b00;
      full         = 2'b00;
      pop          = 2'b00;
      for (int i = 0; i < 2; i++) begin
         rel_tag[i]   = tail_v && (tail_id == 1'(i));
         push[i]      = rel_tag[i] && act_out_valid;
         out_valid[i] = (occ[i] != '0);
         full[i]      = (occ[i] == DEPTH_C);
         pop[i]       = out_valid[i] && out_ready[i];
      end
   end

   assign r0_out_valid = out_valid[0];
   assign r1_out_valid = out_valid[1];
   assign r0_out_data  = out_valid[0] ? mem[0][rd_ptr[0]] : '0;
   assign r1_out_data  = out_valid[1] ? mem[1][rd_ptr[1]] : '0;
   assign busy         = (|tag_v) | out_valid[0] | out_valid[1];

   // Tag pipe, grant history, sticky mismatch flag, credit counters and FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v      <= '0;
         tag_id     <= '0;
         last_grant <= 1'b1;
         err        <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            occ[i]      <= '0;
            inflight[i] <= '0;
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
         end
      end else begin
         tag_v[0]  <= act_in_valid;
         tag_id[0] <= win[1];
         for (int s = 1; s < PIPE_LAT; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
         if (act_in_valid) begin
            last_grant <= win[1];
         end
         if (act_out_valid != tail_v) begin
            err <= 1'b1;
         end
         for (int i = 0; i < 2; i++) begin
            inflight[i] <= inflight[i] + CW'(win[i]) - CW'(rel_tag[i]);
            occ[i]      <= occ[i] + CW'(push[i]) - CW'(pop[i]);
            if (push[i]) begin
               wr_ptr[i] <= next_ptr(wr_ptr[i]);
            end
            if (pop[i]) begin
               rd_ptr[i] <= next_ptr(rd_ptr[i]);
            end
            assert (!(push[i] && full[i]));
         end
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= push_data[i];
         end
      end
   end

endmodule
